bcd_to_angle: RTL and testbench

- Converts a 3-digit BCD degree setpoint (0-359) into a 12-bit encoder angle count, at COUNTS_PER_REV counts per revolution.
- It is the inverse of the display path's count-to-BCD conversion and sits between the setpoint entry logic and the position controller.
- Sequential and multi-cycle: serial reverse double dabble, then constant multiply, then serial restoring division.
- The result is the smallest count whose forward conversion returns the same degree value.

---
 rtl/bcd_angle_pkg.sv | 47 ++++
 rtl/bcd_to_angle_bin.sv | 53 +++++
 rtl/bcd_to_angle.sv | 163 ++++++++++++++++
 tb/tb_bcd_to_angle.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_angle_pkg.sv
// bcd_angle_pkg
// Shared constants, FSM state type and BCD helper functions for the
// BCD degree setpoint -> encoder count conversion path.
//   COUNTS_PER_REV_D / DEG_PER_REV_D : default scaling constants
//   DEG_W  : width of the binary degree value (0..999)
//   BCD_W  : width of a 3-digit BCD word
//   NUM_W  : width of deg*COUNTS + (DEG-1) for an in-range deg
//   DIV_W  : number of restoring-division steps (one per quotient bit)
package bcd_angle_pkg;

  localparam int COUNTS_PER_REV_D = 1006;
  localparam int DEG_PER_REV_D    = 360;
  localparam int DEG_W            = 10;
  localparam int BCD_W            = 12;
  localparam int NUM_W            = $clog2((DEG_PER_REV_D - 1) * COUNTS_PER_REV_D + DEG_PER_REV_D);
  localparam int DIV_W            = NUM_W;

  typedef enum logic [2:0] {
    IDLE,
    BCD,
    MUL,
    DIV,
    DONE
  } state_t;

  // Reverse double dabble correction: after each right shift any nibble
  // that received a carried-in 1 (value >= 8) is reduced by 3.
  function automatic logic [BCD_W-1:0] dabble_fix(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  // True when any nibble of a BCD word is not a decimal digit.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_to_angle_bin.sv
// bcd_to_bin_serial
// Serial reverse double dabble: converts a 3-digit BCD word to binary,
// one bit per clock, BCD_W clocks per conversion.
//   clk     : system clock (rising edge)
//   reset_n : synchronous active-low reset
//   start   : load bcd and begin a conversion (ignored bcd otherwise)
//   bcd     : BCD input word, registered on start
//   done    : high during the final shift cycle; bin is valid from the
//             following cycle and holds until the next start
//   bin     : binary result (value < 1000)
module bcd_to_bin_serial
  import bcd_angle_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd,
  output logic             done,
  output logic [BCD_W-1:0] bin
);

  localparam int STEPS = BCD_W;
  localparam int CNT_W = $clog2(STEPS);

  logic [BCD_W-1:0] sh;
  logic [BCD_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             active;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= bcd;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      // {sh, acc} shifts right as one word; the BCD half is then corrected.
      sh  <= dabble_fix({1'b0, sh[BCD_W-1:1]});
      acc <= {sh[0], acc[BCD_W-1:1]};
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(STEPS - 1)) active <= 1'b0;
    end
  end

  assign done = active && (cnt == CNT_W'(STEPS - 1));
  assign bin  = acc;

endmodule

// File: rtl/bcd_to_angle.sv
// bcd_to_angle
// Converts a 3-digit BCD degree setpoint (0..DEG_PER_REV-1) into the
// smallest encoder count whose forward conversion gives the same degree:
//   angle = ceil(deg * COUNTS_PER_REV / DEG_PER_REV)
// Flow: serial BCD->binary, one multiply cycle, serial restoring division.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   bcd, in_valid        : request ([11:8] hundreds, [7:4] tens, [3:0] units)
//   in_ready             : idle, request accepted on in_valid && in_ready
//   angle, err           : result count / rejected request (bad digit, range)
//   out_valid, out_ready : result handshake; result held until accepted
// Build option: define BCD_ANGLE_CLAMP_EN to clamp deg >= DEG_PER_REV to
// DEG_PER_REV-1 instead of rejecting it (bad digits are still rejected).
module bcd_to_angle
  import bcd_angle_pkg::*;
#(
  parameter int COUNTS_PER_REV = COUNTS_PER_REV_D,
  parameter int DEG_PER_REV    = DEG_PER_REV_D,
  parameter int ANGLE_W        = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [11:0]        bcd,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ANGLE_W-1:0] angle,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int NUM_BITS  = $clog2((DEG_PER_REV - 1) * COUNTS_PER_REV + DEG_PER_REV);
  localparam int DIV_STEPS = NUM_BITS;
  localparam int REM_W     = $clog2(DEG_PER_REV);
  localparam int TRIAL_W   = REM_W + 1;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  state_t state, state_n;

  logic                accept;
  logic                digit_bad;
  logic                conv_start;
  logic                conv_done;
  logic [BCD_W-1:0]    conv_bin;

  logic                deg_oor;
  logic                range_err;
  logic [DEG_W-1:0]    deg_eff;
  logic [NUM_BITS-1:0] num;

  logic [NUM_BITS-1:0] quo, quo_n;
  logic [REM_W-1:0]    rem, rem_n;
  logic [TRIAL_W-1:0]  trial;
  logic [CNT_W-1:0]    div_cnt;
  logic                div_last;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign digit_bad  = has_bad_digit(bcd);
  assign conv_start = accept && !digit_bad;

  bcd_to_bin_serial u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bcd     (bcd),
    .done    (conv_done),
    .bin     (conv_bin)
  );

  // Multiply and one restoring-division step.
  always_comb begin
    deg_oor = (conv_bin >= BCD_W'(DEG_PER_REV));
`ifdef BCD_ANGLE_CLAMP_EN
    deg_eff   = deg_oor ? DEG_W'(DEG_PER_REV - 1) : conv_bin[DEG_W-1:0];
    range_err = 1'b0;
`else
    deg_eff   = conv_bin[DEG_W-1:0];
    range_err = deg_oor;
`endif
    // Adding DEG_PER_REV-1 before the floor division turns it into a ceiling.
    num = NUM_BITS'(deg_eff) * NUM_BITS'(COUNTS_PER_REV) + NUM_BITS'(DEG_PER_REV - 1);

    // quo doubles as dividend shifter: MSB feeds the remainder, quotient
    // bits enter at the LSB.
    trial = {rem, quo[NUM_BITS-1]};
    if (trial >= TRIAL_W'(DEG_PER_REV)) begin
      rem_n = REM_W'(trial - TRIAL_W'(DEG_PER_REV));
      quo_n = {quo[NUM_BITS-2:0], 1'b1};
    end else begin
      rem_n = trial[REM_W-1:0];
      quo_n = {quo[NUM_BITS-2:0], 1'b0};
    end
    div_last = (div_cnt == CNT_W'(DIV_STEPS - 1));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = digit_bad ? DONE : BCD;
      end
      BCD: begin
        if (conv_done) state_n = MUL;
      end
      MUL: begin
        state_n = range_err ? DONE : DIV;
      end
      DIV: begin
        if (div_last) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      angle   <= '0;
      err     <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      div_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && digit_bad) begin
            angle <= '0;
            err   <= 1'b1;
          end
        end
        MUL: begin
          quo     <= num;
          rem     <= '0;
          div_cnt <= '0;
          if (range_err) begin
            angle <= '0;
            err   <= 1'b1;
          end
        end
        DIV: begin
          quo     <= quo_n;
          rem     <= rem_n;
          div_cnt <= div_cnt + 1'b1;
          if (div_last) begin
            angle <= quo_n[ANGLE_W-1:0];
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_angle.sv
// tb_bcd_to_angle
// Directed self-checking bench for bcd_to_angle. Latencies are counted in
// falling edges after the accept edge (1 = the cycle right after accept).
module tb_bcd_to_angle;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] bcd;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] angle;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  bcd_to_angle #(
    .COUNTS_PER_REV (1006),
    .DEG_PER_REV    (360),
    .ANGLE_W        (12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bcd       (bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int d);
    logic [3:0] h, t, u;
    h = 4'(d / 100);
    t = 4'((d / 10) % 10);
    u = 4'(d % 10);
    return {h, t, u};
  endfunction

  // Display-path forward conversion: count -> whole degrees.
  function automatic int fwd(input int c);
    return (c * 360) / 1006;
  endfunction

  // Wait for out_valid (bounded); lat = 0 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  // One request with out_ready high; returns result and latency.
  task automatic do_req(input logic [11:0] v, output logic [11:0] a, output logic e, output int lat);
    @(negedge clk);
    check("ready_before", in_ready, 1);
    bcd      = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd      = 12'hAAA;
    wait_result(lat);
    a = angle;
    e = err;
    @(negedge clk);
    check("ready_after", in_ready, 1);
  endtask

  task automatic expect_req(input string tag, input logic [11:0] v,
                            input int unsigned ea, input int unsigned ee, input int unsigned el);
    logic [11:0] a;
    logic        e;
    int          lat;
    do_req(v, a, e, lat);
    check($sformatf("%s_angle", tag), a, ea);
    check($sformatf("%s_err", tag), e, ee);
    check($sformatf("%s_lat", tag), lat, el);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] a;
    logic        e;
    int          lat;
    int          stale;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bcd       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_angle", angle, 0);
    check("rst_err", err, 0);

    expect_req("e000", 12'h000, 0, 0, 33);
    expect_req("e001", 12'h001, 3, 0, 33);
    expect_req("e359", 12'h359, 1004, 0, 33);
    expect_req("r090", 12'h090, 252, 0, 33);
    expect_req("r180", 12'h180, 503, 0, 33);
    expect_req("d3A0", 12'h3A0, 0, 1, 1);
    expect_req("d00F", 12'h00F, 0, 1, 1);
`ifdef BCD_ANGLE_CLAMP_EN
    expect_req("o360", 12'h360, 1004, 0, 33);
    expect_req("o999", 12'h999, 1004, 0, 33);
`else
    expect_req("o360", 12'h360, 0, 1, 14);
    expect_req("o999", 12'h999, 0, 1, 14);
`endif
    expect_req("pre_abort", 12'h359, 1004, 0, 33);

    // Abort mid-conversion with a 3-cycle reset.
    @(negedge clk);
    bcd      = 12'h123;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_angle", angle, 0);
    check("abort_err", err, 0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("abort_no_stale", stale, 0);

    // Backpressure: result held, second request waits for the handshake.
    out_ready = 1'b0;
    @(negedge clk);
    bcd      = 12'h180;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_lat", lat, 33);
    bcd      = 12'h090;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_angle", angle, 503);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rearm", in_ready, 1);
    check("bp_released", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("bp2_lat", lat, 33);
    check("bp2_angle", angle, 252);
    check("bp2_err", err, 0);
    @(negedge clk);

    // Sweep: result is the smallest count that maps back to deg.
    for (int d = 0; d < 360; d++) begin
      do_req(to_bcd(d), a, e, lat);
      check("sweep_fwd", fwd(int'(a)), d);
      check("sweep_err", e, 0);
      if (d > 0) check("sweep_min", (fwd(int'(a) - 1) < d) ? 1 : 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
